// File: rtl/flit_injector.sv
// flit_injector: network-interface transmit stage feeding a mesh router's
// local input port. Turns a (destination, length) descriptor plus a stream of
// payload words into HEADER / BODY / TAIL flits over an enable/ack handshake,
// one packet in flight at a time.

package flit_injector_pkg;

    localparam int unsigned PAYLOAD_W = 32;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        HEADER   = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        addr_t       dst_addr;
        addr_t       src_addr;
        logic [15:0] rsvd;
    } control_hdr_t;

    typedef struct packed {
        flit_type_t           flit_type;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam int unsigned ADDR_W = $bits(addr_t);
    localparam int unsigned FLIT_W = $bits(flit_t);

endpackage

module flit_injector
    import flit_injector_pkg::*;
#(
    parameter int X     = 1,
    parameter int Y     = 1,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [ADDR_W-1:0]    msg_dst,
    input  logic [LEN_W-1:0]     msg_len,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [PAYLOAD_W-1:0] data_word,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 enable_o,
    input  logic                 ack_i,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LOAD,
        SEND
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    flit_t            flit_q;
    control_hdr_t     hdr;
    addr_t            own_addr;

    assign flit_o = flit_q;

    // Header payload built from the live descriptor and this router's coordinates.
    always_comb begin
        own_addr   = '0;
        own_addr.x = 4'(X);
        own_addr.y = 4'(Y);
        hdr          = '0;
        hdr.dst_addr = addr_t'(msg_dst);
        hdr.src_addr = own_addr;
    end

    // Packet sequencer; every output is a register updated alongside the state.
    // The header flit is loaded on the descriptor handshake itself, so HDR is
    // entered with the header already presented and no separate dst register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            flit_q     <= '0;
            enable_o   <= 1'b0;
            msg_ready  <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    msg_ready <= 1'b1;
                    if (msg_valid && msg_ready) begin
                        remaining        <= msg_len;
                        flit_q.flit_type <= HEADER;
                        flit_q.payload   <= hdr;
                        enable_o         <= 1'b1;
                        msg_ready        <= 1'b0;
                        busy             <= 1'b1;
                        state            <= HDR;
                    end
                end
                HDR: begin
                    if (enable_o && ack_i) begin
                        if (remaining == '0) begin
                            flit_q.flit_type <= TAIL;
                            flit_q.payload   <= '0;
                            state            <= SEND;
                        end else begin
                            enable_o   <= 1'b0;
                            data_ready <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (data_valid && data_ready) begin
                        flit_q.flit_type <= (remaining == LEN_W'(1)) ? TAIL : BODY;
                        flit_q.payload   <= data_word;
                        remaining        <= remaining - LEN_W'(1);
                        enable_o         <= 1'b1;
                        data_ready       <= 1'b0;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    if (enable_o && ack_i) begin
                        enable_o <= 1'b0;
                        if (flit_q.flit_type == TAIL) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            data_ready <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Self-addressed packets are forwarded untouched; flag them for the integrator.
    a_no_self_dst: assert property (@(posedge clk) disable iff (rst)
        (msg_valid && msg_ready) |-> (addr_t'(msg_dst) != own_addr))
        else $warning("flit_injector: destination equals own router address");

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: a table of packets with hand-computed flit
// sequences, plus hand-written stall, gap, back-to-back and reset sequences.

module tb_flit_injector;
    import flit_injector_pkg::*;

    logic        clk;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_dst;
    logic [7:0]  msg_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_word;
    logic [33:0] flit_o;
    logic        enable_o;
    logic        ack_i;
    logic        busy;

    flit_injector #(.X(1), .Y(1), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_dst    (msg_dst),
        .msg_len    (msg_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_word  (data_word),
        .flit_o     (flit_o),
        .enable_o   (enable_o),
        .ack_i      (ack_i),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        dst;
        int                len;
        logic [2:0][31:0]  w;
        int                nexp;
        logic [3:0][33:0]  exp;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;

    logic [33:0] got[$];
    int en_cycles   = 0;
    int hold_cycles = 0;
    int dr_cycles   = 0;
    int pkt_base    = 0;
    int stall_plan[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Observer at the falling edge: records transfers and checks hold stability.
    initial begin
        logic        have_prev;
        logic        prev_en;
        logic        prev_ack;
        logic [33:0] prev_flit;
        have_prev = 1'b0;
        prev_en   = 1'b0;
        prev_ack  = 1'b0;
        prev_flit = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
                continue;
            end
            if (have_prev) begin
                if (prev_en && !prev_ack) begin
                    chk("hold_enable", 64'(enable_o), 64'(1'b1));
                    chk("hold_flit", 64'(flit_o), 64'(prev_flit));
                end else if (!prev_en && !enable_o) begin
                    chk("idle_flit", 64'(flit_o), 64'(prev_flit));
                end
            end
            if (busy) chk("msg_ready_busy", 64'(msg_ready), 64'(1'b0));
            if (data_ready) chk("load_enable", 64'(enable_o), 64'(1'b0));
            if (enable_o) en_cycles++;
            if (enable_o && !ack_i) hold_cycles++;
            if (data_ready) dr_cycles++;
            if (enable_o && ack_i) got.push_back(flit_o);
            prev_en   = enable_o;
            prev_ack  = ack_i;
            prev_flit = flit_o;
            have_prev = 1'b1;
        end
    end

    // Router model: acks each flit after stall_plan[flit index] held cycles.
    initial begin
        int seen;
        int stall_cnt;
        int idx;
        seen = 0;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (got.size() != seen) begin
                seen = got.size();
                stall_cnt = 0;
            end
            if (rst) stall_cnt = 0;
            idx = got.size() - pkt_base;
            if (idx < 0 || idx > 7) idx = 7;
            if (enable_o) begin
                if (stall_cnt < stall_plan[idx]) begin
                    ack_i = 1'b0;
                    stall_cnt++;
                end else begin
                    ack_i = 1'b1;
                end
            end else begin
                ack_i = 1'b1;
            end
        end
    end

    task automatic send_msg(input logic [7:0] dst, input int len);
        int n;
        msg_valid = 1'b1;
        msg_dst   = dst;
        msg_len   = 8'(len);
        n = 0;
        while (!msg_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeout("msg_ready_wait");
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] w, input int gap, input logic [33:0] hold);
        int n;
        if (gap == 0) begin
            data_valid = 1'b1;
            data_word  = w;
        end
        n = 0;
        while (!data_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeout("data_ready_wait");
        for (int g = 0; g < gap; g++) begin
            chk("gap_enable", 64'(enable_o), 64'(1'b0));
            chk("gap_flit", 64'(flit_o), 64'(hold));
            chk("gap_data_ready", 64'(data_ready), 64'(1'b1));
            @(posedge clk);
            #1;
        end
        data_valid = 1'b1;
        data_word  = w;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n);
        int c;
        c = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
        end while (got.size() < n && c < 300);
        if (got.size() < n) timeout("flit_wait");
    endtask

    task automatic check_flits(input string name, input int base, input vec_t v);
        chk({name, "_count"}, 64'(got.size() - base), 64'(v.nexp));
        for (int k = 0; k < v.nexp; k++) begin
            if (base + k < got.size())
                chk($sformatf("%s_flit%0d", name, k), 64'(got[base + k]), 64'(v.exp[k]));
        end
    endtask

    task automatic run_pkt(input string name, input vec_t v);
        int base;
        int en0;
        int h0;
        int dr0;
        base = got.size();
        pkt_base = base;
        en0 = en_cycles;
        h0  = hold_cycles;
        dr0 = dr_cycles;
        send_msg(v.dst, v.len);
        for (int i = 0; i < v.len; i++) feed_word(v.w[i], 0, '0);
        wait_flits(base + v.nexp);
        check_flits(name, base, v);
        chk({name, "_en_cycles"}, 64'(en_cycles - en0), 64'(v.nexp + hold_cycles - h0));
        if (v.len == 0) chk({name, "_no_data_ready"}, 64'(dr_cycles - dr0), 64'(0));
        chk({name, "_busy_after_tail"}, 64'(busy), 64'(1'b0));
        chk({name, "_enable_after_tail"}, 64'(enable_o), 64'(1'b0));
        chk({name, "_msg_ready_after_tail"}, 64'(msg_ready), 64'(1'b0));
        @(posedge clk);
        #2;
        chk({name, "_msg_ready_idle"}, 64'(msg_ready), 64'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < 8; i++) stall_plan[i] = 0;

        // Header payload = {dst.x, dst.y, src.x=1, src.y=1, 16'h0}; type codes 0/1/2.
        vecs[0].dst = 8'h21; vecs[0].len = 3;
        vecs[0].w[0] = 32'hAAAA_0001; vecs[0].w[1] = 32'hBBBB_0002; vecs[0].w[2] = 32'hCCCC_0003;
        vecs[0].nexp = 4;
        vecs[0].exp[0] = {2'd0, 32'h2111_0000};
        vecs[0].exp[1] = {2'd1, 32'hAAAA_0001};
        vecs[0].exp[2] = {2'd1, 32'hBBBB_0002};
        vecs[0].exp[3] = {2'd2, 32'hCCCC_0003};

        vecs[1].dst = 8'h03; vecs[1].len = 0; vecs[1].w = '0;
        vecs[1].nexp = 2;
        vecs[1].exp[0] = {2'd0, 32'h0311_0000};
        vecs[1].exp[1] = {2'd2, 32'h0000_0000};
        vecs[1].exp[2] = '0; vecs[1].exp[3] = '0;

        vecs[2].dst = 8'h32; vecs[2].len = 1; vecs[2].w = '0;
        vecs[2].w[0] = 32'hDEAD_BEEF;
        vecs[2].nexp = 2;
        vecs[2].exp[0] = {2'd0, 32'h3211_0000};
        vecs[2].exp[1] = {2'd2, 32'hDEAD_BEEF};
        vecs[2].exp[2] = '0; vecs[2].exp[3] = '0;

        vecs[3].dst = 8'h10; vecs[3].len = 2; vecs[3].w = '0;
        vecs[3].w[0] = 32'h1234_5678; vecs[3].w[1] = 32'h8765_4321;
        vecs[3].nexp = 3;
        vecs[3].exp[0] = {2'd0, 32'h1011_0000};
        vecs[3].exp[1] = {2'd1, 32'h1234_5678};
        vecs[3].exp[2] = {2'd2, 32'h8765_4321};
        vecs[3].exp[3] = '0;

        rst = 1'b1;
        msg_valid = 1'b0; msg_dst = '0; msg_len = '0;
        data_valid = 1'b0; data_word = '0;
        ack_i = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_flit", 64'(flit_o), 64'(0));
        chk("reset_enable", 64'(enable_o), 64'(0));
        chk("reset_msg_ready", 64'(msg_ready), 64'(0));
        chk("reset_data_ready", 64'(data_ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post_reset_msg_ready", 64'(msg_ready), 64'(1'b1));

        // Table of packets with the router acking immediately.
        for (int v = 0; v < 4; v++) run_pkt($sformatf("vec%0d", v), vecs[v]);

        // Header stalled 5 cycles, BODY B stalled 3 cycles.
        n = hold_cycles;
        stall_plan[0] = 5;
        stall_plan[2] = 3;
        run_pkt("stall", vecs[0]);
        chk("stall_hold_cycles", 64'(hold_cycles - n), 64'(8));
        stall_plan[0] = 0;
        stall_plan[2] = 0;

        // Payload word B withheld 4 cycles while BODY A stays on flit_o.
        base = got.size();
        pkt_base = base;
        send_msg(8'h21, 3);
        feed_word(32'hAAAA_0001, 0, '0);
        feed_word(32'hBBBB_0002, 4, {2'd1, 32'hAAAA_0001});
        feed_word(32'hCCCC_0003, 0, '0);
        wait_flits(base + 4);
        check_flits("gap", base, vecs[0]);

        // Second descriptor held pending during the first packet.
        @(posedge clk);
        #1;
        base = got.size();
        pkt_base = base;
        send_msg(vecs[0].dst, vecs[0].len);
        msg_valid = 1'b1;
        msg_dst   = vecs[3].dst;
        msg_len   = 8'(vecs[3].len);
        for (int i = 0; i < 3; i++) feed_word(vecs[0].w[i], 0, '0);
        n = 0;
        while (!msg_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeout("b2b_ready_wait");
        chk("b2b_first_done", 64'(got.size() - base), 64'(4));
        chk("b2b_idle_busy", 64'(busy), 64'(1'b0));
        check_flits("b2b_a", base, vecs[0]);
        pkt_base = got.size();
        send_msg(vecs[3].dst, vecs[3].len);
        for (int i = 0; i < 2; i++) feed_word(vecs[3].w[i], 0, '0);
        wait_flits(base + 7);
        check_flits("b2b_b", base + 4, vecs[3]);

        // Asynchronous reset while BODY A is held by the router.
        @(posedge clk);
        #1;
        pkt_base = got.size();
        stall_plan[1] = 10;
        send_msg(8'h21, 3);
        feed_word(32'hAAAA_0001, 0, '0);
        @(posedge clk);
        #3;
        chk("pre_reset_flit", 64'(flit_o), 64'({2'd1, 32'hAAAA_0001}));
        chk("pre_reset_enable", 64'(enable_o), 64'(1'b1));
        rst = 1'b1;
        #1;
        chk("async_reset_flit", 64'(flit_o), 64'(0));
        chk("async_reset_enable", 64'(enable_o), 64'(0));
        chk("async_reset_msg_ready", 64'(msg_ready), 64'(0));
        chk("async_reset_data_ready", 64'(data_ready), 64'(0));
        chk("async_reset_busy", 64'(busy), 64'(0));
        stall_plan[1] = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        run_pkt("after_reset", vecs[0]);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Network-interface transmit stage that sits directly upstream of a mesh router's local input port.
- Accepts a message descriptor (destination, word count) plus a stream of payload words from a local core.
- Serialises them into HEADER, BODY and TAIL flits using the router's enable/ack handshake.
- Holds one packet in flight at a time and preserves wormhole ordering.

Parameters:
- X, 1, column coordinate of the attached router; written into header src_addr.x.
- Y, 1, row coordinate of the attached router; written into header src_addr.y.
- LEN_W, 8, width of the message word count.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- msg_valid  input  1  descriptor valid.
- msg_ready  output  1  descriptor accepted when msg_valid && msg_ready.
- msg_dst  input  $bits(addr_t)  destination router address.
- msg_len  input  LEN_W  number of payload words; 0 is legal.
- data_valid  input  1  payload word valid.
- data_ready  output  1  payload word consumed when data_valid && data_ready.
- data_word  input  $bits(flit_t.payload)  payload word.
- flit_o  output  $bits(flit_t)  flit towards router.
- enable_o  output  1  flit_o is valid.
- ack_i  input  1  router accepts flit (combinational grant).
- busy  output  1  packet in progress (state != IDLE).

Behaviour:
- Transfer rule: a flit transfers in a cycle where enable_o && ack_i.
  - While enable_o=1 and ack_i=0, flit_o and enable_o hold stable.
  - Once raised, enable_o is never dropped before the transfer completes.
- flit_o changes only when a new flit is loaded.
  - When enable_o=0, flit_o keeps its last value.
  - A TAIL is therefore never presented ahead of its own handshake.
  - A held BODY/HEADER does not free the router path.
- Reset values: flit_o='0, enable_o=0, msg_ready=0, data_ready=0, busy=0, state=IDLE, remaining count=0.
  - Reset mid-packet aborts immediately.
  - Reset does not emit a tail; the bench re-resets the router alongside.
- FSM states: IDLE, HDR, LOAD, SEND.
  - IDLE:
    - msg_ready=1.
    - On descriptor handshake, latch dst and len into remaining count, then go to HDR.
  - HDR:
    - Load flit_o with flit_type=HEADER, payload=control_hdr_t{dst_addr=msg_dst, src_addr={X,Y}, other fields 0}, and raise enable_o.
    - On transfer: if len==0, go to SEND with a preloaded TAIL whose payload is 0; otherwise go to LOAD.
    - Header-to-next-flit latency: the next flit is presented no earlier than 1 cycle after the header transfer.
  - LOAD:
    - data_ready=1 and enable_o=0.
    - On data handshake, load flit_o.payload=data_word and raise enable_o next cycle.
    - flit_type=TAIL when remaining==1, else BODY.
    - Decrement remaining, then go to SEND.
  - SEND:
    - enable_o=1.
    - On transfer: if the sent flit was TAIL, go to IDLE with enable_o=0. Otherwise go to LOAD.
- Throughput: at most 1 flit every 2 cycles (LOAD/SEND alternation). A bypass is not required.
- data_ready=0 outside LOAD; payload words are never consumed early or dropped.
- remaining is an unsigned LEN_W counter with no wrap.
  - Maximum packet length is 2^LEN_W-1 payload words plus the header.
- msg_ready=0 whenever busy=1. A new descriptor is accepted only in IDLE, at least 1 cycle after TAIL transfer.
- Simultaneous events:
  - ack_i asserted while enable_o=0 is ignored.
  - msg_valid during busy is held off by msg_ready=0.
  - data_valid outside LOAD is ignored.
- A destination equal to {X,Y} is passed through unchanged. Filtering is not this block's job; an assertion warns.

Test Plan:
- Reset, then msg_dst={2,1}, msg_len=3, words A,B,C, ack_i tied 1 -> flit sequence HEADER(dst {2,1}, src {1,1}), BODY A, BODY B, TAIL C. Each enable_o is high exactly 1 cycle; busy falls the cycle after TAIL.
- msg_len=0 -> exactly HEADER then TAIL with payload 0; data_ready never asserts.
- Same message with ack_i=0 for 5 cycles on the header and 3 cycles on BODY B -> flit_o/enable_o stable throughout each stall. No duplicates, no loss; TAIL type is never visible before C.
- data_valid withheld 4 cycles before word B -> enable_o=0 during the gap and flit_o stays BODY A. The stream resumes correctly.
- Back-to-back descriptors, second presented during the first packet -> msg_ready=0 until after TAIL. The second HEADER follows, and the packets are not interleaved.
- Assert rst mid-BODY -> all outputs return to reset values asynchronously. The next message is injected from HEADER cleanly.
